shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Sequential shift-and-add unsigned multiplier. It is the inverse-direction companion to the restoring divider: it rebuilds dividend = quotient × divisor and produces general products for the arithmetic unit.
- Contains its own controller FSM, a multiplicand register, an accumulator/multiplier shift pair and an iteration counter.
- Takes WIDTH-bit operands and produces a 2×WIDTH-bit product, with start/done handshake and status flags.

Parameters:
- WIDTH, 10: operand width in bits; product is 2*WIDTH.
- CNT_W, 4: iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  reset, asynchronous and active-low; clears all state when 0.
- start  in  1  request; sampled only in IDLE.
- a_in  in  WIDTH  multiplier operand; sampled on the edge that accepts start.
- b_in  in  WIDTH  multiplicand operand; sampled on the edge that accepts start.
- busy  out  1  high in LOAD and CALC.
- done  out  1  high for exactly one cycle, in DONE state.
- product  out  2*WIDTH  result; held stable from DONE until the next accepted start reaches LOAD.
- overflow  out  1  product[2*WIDTH-1:WIDTH] != 0, i.e. the result does not fit WIDTH bits; valid with product.
- zero_operand  out  1  the last accepted a_in or b_in was 0; valid with product.

Behaviour:
- Reset (clr=0, async): state=IDLE, all registers 0, so product=0, busy=0, done=0, overflow=0, zero_operand=0. Reset mid-operation aborts immediately; no partial result is retained.
- Registers:
  - M (WIDTH): multiplicand.
  - ACC (WIDTH+1): upper partial product plus carry.
  - Q (WIDTH): multiplier, shifted right.
  - cnt (CNT_W).
- FSM states: IDLE, LOAD, CALC, DONE.
- IDLE:
  - start=1 with a_in!=0 and b_in!=0: latch operands into Q<=a_in and M<=b_in, go to LOAD.
  - start=1 with a_in==0 or b_in==0: ACC<=0, Q<=0, zero_operand<=1, go straight to DONE (no iteration).
- LOAD: ACC<=0, cnt<=0, zero_operand<=0, next state CALC. Takes one cycle.
- CALC, one iteration per cycle:
  - sum = Q[0] ? ({1'b0,ACC[WIDTH-1:0]} + {1'b0,M}) : {1'b0,ACC[WIDTH-1:0]}, computed WIDTH+1 bits wide.
  - Then {ACC,Q} <= {1'b0,sum,Q} >> 1.
  - cnt increments each iteration. When cnt==WIDTH-1, go to DONE after that iteration's update; exactly WIDTH iterations run.
- DONE: done=1 for one cycle, next state IDLE unconditionally. start is ignored in DONE.
- product = {ACC[WIDTH-1:0],Q}, driven continuously from the registers. ACC[WIDTH] is always 0 after the final shift.
- Latency: start seen high at edge E1.
  - Normal case: LOAD after E1, CALC through E2..E(WIDTH+1), DONE after E(WIDTH+2). For WIDTH=10, done is high in the cycle after the 12th edge.
  - Zero-operand case: DONE after E1.
- start while busy or in DONE: ignored; operands are not resampled.
- Result hold: a_in/b_in changes after acceptance do not affect the operation.
- Back-to-back: start held high continuously is accepted again on the first IDLE cycle after DONE, giving one result per WIDTH+3 cycles.
- Arithmetic is unsigned only. Maximum product is (2**WIDTH-1)**2, which fits 2*WIDTH bits.

Decomposition:
- Shared arithmetic package holds the state encoding constants (IDLE=0, LOAD=1, CALC=2, DONE=3) and the default WIDTH/CNT_W, so the divider and multiplier controllers agree.
- One natural sub-module: mult_controller (FSM plus counter, producing load/shift/add-enable signals). The datapath stays in the top.
- The adder and counter can reuse the existing team adder/counter style as plain instances.

Test Plan:
- Reset then idle: clr=0 then 1 with no start -> product=0, busy=0, done=0, overflow=0 throughout.
- 12 × 13 (a_in=12, b_in=13, start pulse) -> busy high from the cycle after E1; done one cycle after the 12th edge; product=156, overflow=0, zero_operand=0; product still 156 ten cycles later.
- 1023 × 1023 -> product=1046529 (0xFF801), overflow=1; 1023 × 1 -> product=1023, overflow=0.
- 0 × 500 -> done high the cycle after E1, product=0, zero_operand=1, busy never asserted.
- Mid-operation: start 37 × 25, pulse start again with 3 × 3 during CALC -> ignored, product=925. Next run: start 37 × 25, assert clr=0 at the 6th edge -> immediate reset values, FSM IDLE, no done pulse.
- Back-to-back: start held high with a_in=100, b_in=100 -> done pulses exactly 13 cycles apart, product=10000 each time, overflow=1.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default sizes
// used by the shift-add multiplier and the restoring divider.
package shift_add_multiplier_pkg;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/shift_add_multiplier_ctrl.sv
// Controller for the shift-add multiplier: FSM and iteration counter.
// In: clk, clr, start, operand_zero. Out: load/clear/shift strobes, busy, done.
module mult_controller
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic operand_zero,
    output logic load_op,
    output logic zero_go,
    output logic clear_acc,
    output logic shift_en,
    output logic busy,
    output logic done
);

    state_t state;
    state_t state_nx;
    logic [CNT_W-1:0] cnt;
    logic last_iter;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (clear_acc) begin
                cnt <= '0;
            end else if (shift_en) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        load_op   = 1'b0;
        zero_go   = 1'b0;
        clear_acc = 1'b0;
        shift_en  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (operand_zero) begin
                        zero_go  = 1'b1;
                        state_nx = DONE;
                    end else begin
                        load_op  = 1'b1;
                        state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                clear_acc = 1'b1;
                busy      = 1'b1;
                state_nx  = CALC;
            end
            CALC: begin
                shift_en = 1'b1;
                busy     = 1'b1;
                if (last_iter) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// In: clk, clr, start, a_in, b_in. Out: busy, done, product, overflow, zero_operand.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow,
    output logic               zero_operand
);

    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic operand_zero;
    logic load_op;
    logic zero_go;
    logic clear_acc;
    logic shift_en;

    assign operand_zero = (a_in == '0) || (b_in == '0);

    mult_controller #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .operand_zero(operand_zero),
        .load_op     (load_op),
        .zero_go     (zero_go),
        .clear_acc   (clear_acc),
        .shift_en    (shift_en),
        .busy        (busy),
        .done        (done)
    );

    assign addend = q[0] ? m : '0;
    assign sum    = {1'b0, acc[WIDTH-1:0]} + {1'b0, addend};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            m            <= '0;
            acc          <= '0;
            q            <= '0;
            zero_operand <= 1'b0;
        end else begin
            if (load_op) begin
                q <= a_in;
                m <= b_in;
            end
            if (zero_go) begin
                acc          <= '0;
                q            <= '0;
                zero_operand <= 1'b1;
            end
            if (clear_acc) begin
                acc          <= '0;
                zero_operand <= 1'b0;
            end
            // Carry from the add lands in acc's MSB-1 after the shift.
            if (shift_en) begin
                acc <= {1'b0, sum[WIDTH:1]};
                q   <= {sum[0], q[WIDTH-1:1]};
            end
        end
    end

    assign product  = {acc[WIDTH-1:0], q};
    // acc[WIDTH] is zero after every shift, so this equals |product upper half.
    assign overflow = |acc;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier.
// Drives vectors #1 after rising edges and checks at the same point.
module tb_shift_add_multiplier;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy;
    logic         done;
    logic [2*W-1:0] product;
    logic         overflow;
    logic         zero_operand;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(.WIDTH(W), .CNT_W(4)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .a_in        (a_in),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .overflow    (overflow),
        .zero_operand(zero_operand)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation, waits for done (bounded) and checks results.
    task automatic mul(input string tag, input int a, input int b,
                       input int exp_p, input int exp_ovf,
                       input int exp_zo, input int exp_lat);
        int n;
        logic busy_seen;
        a_in  = W'(a);
        b_in  = W'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        busy_seen = busy;
        while (!done && n < 40) begin
            tick();
            n++;
            busy_seen = busy_seen | busy;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_busy"}, 32'(busy_seen), (exp_lat == 1) ? 32'd0 : 32'd1);
        chk({tag, "_prod"}, 32'(product), 32'(exp_p));
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, "_zo"}, 32'(zero_operand), 32'(exp_zo));
        tick();
        chk({tag, "_done1"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int t;
        int d_cnt;
        int d_at [3];
        logic any_done;

        // Reset then idle
        #2;
        chk("rst_prod", 32'(product), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_zo", 32'(zero_operand), 32'd0);
        tick();
        clr = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            any_done = any_done | done | busy | overflow | (product != 0);
        end
        chk("idle_quiet", 32'(any_done), 32'd0);

        // 12 x 13 with hold check
        a_in  = 10'd12;
        b_in  = 10'd13;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("m12_busy_e1", 32'(busy), 32'd1);
        a_in = 10'd999;
        b_in = 10'd999;
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("m12_lat", 32'(n), 32'd12);
        chk("m12_prod", 32'(product), 32'd156);
        chk("m12_ovf", 32'(overflow), 32'd0);
        chk("m12_zo", 32'(zero_operand), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("m12_hold", 32'(product), 32'd156);
        chk("m12_idle", 32'(busy | done), 32'd0);

        mul("max", 1023, 1023, 1046529, 1, 0, 12);
        mul("x1", 1023, 1, 1023, 0, 0, 12);
        mul("zero", 0, 500, 0, 0, 1, 1);
        mul("after0", 7, 9, 63, 0, 0, 12);

        // Start during CALC is ignored
        a_in  = 10'd37;
        b_in  = 10'd25;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (n == 4) begin
                a_in  = 10'd3;
                b_in  = 10'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk("ign_lat", 32'(n), 32'd12);
        chk("ign_prod", 32'(product), 32'd925);
        tick();
        tick();
        chk("ign_noretrig", 32'(busy | done), 32'd0);

        // Reset mid-operation
        a_in  = 10'd37;
        b_in  = 10'd25;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 2; i <= 5; i++) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        @(posedge clk);
        clr = 1'b0;
        #1;
        chk("mid_prod", 32'(product), 32'd0);
        chk("mid_busy0", 32'(busy), 32'd0);
        chk("mid_done0", 32'(done), 32'd0);
        chk("mid_ovf0", 32'(overflow), 32'd0);
        tick();
        clr = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            any_done = any_done | done | busy;
        end
        chk("mid_idle", 32'(any_done), 32'd0);

        // Back-to-back with start held
        a_in  = 10'd100;
        b_in  = 10'd100;
        start = 1'b1;
        d_cnt = 0;
        for (t = 1; t <= 45; t++) begin
            tick();
            if (done) begin
                if (d_cnt < 3) d_at[d_cnt] = t;
                d_cnt++;
                chk("b2b_prod", 32'(product), 32'd10000);
                chk("b2b_ovf", 32'(overflow), 32'd1);
            end
        end
        start = 1'b0;
        chk("b2b_cnt", 32'(d_cnt), 32'd3);
        if (d_cnt >= 3) begin
            chk("b2b_first", 32'(d_at[0]), 32'd12);
            chk("b2b_gap1", 32'(d_at[1] - d_at[0]), 32'd13);
            chk("b2b_gap2", 32'(d_at[2] - d_at[1]), 32'd13);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
